md_unit: RTL
============

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits in the execute stage beside the ALU, upstream of the data-memory/writeback stage.
- Decodes the current instruction word itself.
- Supplies HI/LO through MdResult for MFHI/MFLO, which the ALU-result mux passes on as Result.
- Raises Stall so the fetch stage holds PC while a dependent HI/LO instruction waits.

Parameters:
- DATA_W, 32, operand/HI/LO width (only 32 supported)
- CNT_W, 6, iteration counter width (must hold DATA_W)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- Ins  in  32  current instruction word (Opcode = Ins[31:26], Funct = Ins[5:0])
- Rdata1  in  32  rs value (multiplicand/dividend; MTHI/MTLO source)
- Rdata2  in  32  rt value (multiplier/divisor)
- Stall  out  1  hold PC/Ins this cycle (combinational)
- Busy  out  1  operation in progress (registered)
- MdResult  out  32  HI for MFHI, LO for MFLO, else 0 (combinational)
- HI  out  32  HI register
- LO  out  32  LO register

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST).
- Reset, including mid-operation: state=IDLE; HI=LO=0; Busy=0; counter=0; the operation is discarded.
- Decode is valid only when Opcode==R_FORM. Funct values: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
- FSM states:
  - IDLE
  - MUL
  - DIV
  - FIX: signed-correction cycle
- IDLE transitions:
  - On a mult/div op with Stall=0: latch operands at the edge and store |operand| magnitudes for signed ops.
  - Record the result signs: q_neg = sa^sb; r_neg = sa.
  - Counter=0, Busy=1, go to MUL or DIV.
  - PC advances past the issuing instruction; there is no stall on issue.
- MUL: shift-add, one multiplier bit per cycle, 32 cycles, 64-bit accumulator. Then go to FIX.
- DIV: restoring division, one quotient bit per cycle, 32 cycles. Then go to FIX.
- FIX transitions:
  - Apply negation to the product (signed MULT) or to the quotient/remainder (signed DIV).
  - Write HI = product[63:32] or remainder; LO = product[31:0] or quotient.
  - Go to IDLE with Busy=0 at the same edge.
- Total latency: issue edge + 33 cycles until HI/LO are valid, so the first non-stalled MFHI reads the new value 34 cycles after issue.
- Stall = Busy && Ins is any of the 8 HI/LO instructions. A new mult/div while busy stalls; there is no queueing.
- MTHI/MTLO when not stalled: HI (or LO) = Rdata1 at the edge; MdResult reflects the new value next cycle.
- Divide by zero: no trap. HI = dividend as given (unsigned/raw), LO = 0xFFFFFFFF, after the normal 33-cycle latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Non-HI/LO instructions never stall and never disturb HI/LO.

Optional Feature:
- Macro MD_FAST_MUL_EN.
- Defined: MULT/MULTU compute in MUL in 1 cycle using the 64-bit * operator on magnitudes, then FIX. Latency is 2 cycles after issue. DIV is unchanged.
- Undefined: the iterative 32-cycle multiplier as described above.

Decomposition:
- common_param.vh gets:
  - funct constants MULT, MULTU, DIV, DIVU, MFHI, MTHI, MFLO, MTLO
  - FSM encodings MD_IDLE, MD_MUL, MD_DIV, MD_FIX
  - DATA_W
- Sub-module md_divider: iterative restoring divider core. Ports CLK, RST, start, dividend, divisor, quotient, remainder, done. md_unit owns the sign handling and the HI/LO registers.

Test Plan:
- RST mid-DIV at cycle 10 -> next cycle Busy=0, HI=LO=0, Stall=0; subsequent MFHI returns 0.
- MULT 0xFFFFFFFE * 0x00000003, then MFLO issued immediately -> Stall high for 33 cycles; then MdResult: LO=0xFFFFFFFA, HI=0xFFFFFFFF. Repeat as MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100 / 7 -> LO=14, HI=2.
- DIVU 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xDEADBEEF while idle -> MFHI next instruction returns 0xDEADBEEF with no stall. MTLO issued while Busy -> Stall until FIX completes, then LO = Rdata1 (overwrites the op result).
- Non-HI/LO instruction (ADD) during Busy -> Stall=0; with MD_FAST_MUL_EN, MULT 6*7 -> LO=42 readable 2 cycles after issue.

Source files
------------

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared constants, FSM encoding and helpers for the multiply/divide unit.
//   DATA_W     operand / HI / LO width (only 32 supported)
//   R_FORM     opcode of register-form instructions that carry a funct field
//   MULT..MTLO funct codes of the eight HI/LO instructions
//   md_state_e FSM states MD_IDLE, MD_MUL, MD_DIV, MD_FIX
package md_unit_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [5:0] R_FORM = 6'h00;

   localparam logic [5:0] MULT  = 6'h18;
   localparam logic [5:0] MULTU = 6'h19;
   localparam logic [5:0] DIV   = 6'h1A;
   localparam logic [5:0] DIVU  = 6'h1B;
   localparam logic [5:0] MFHI  = 6'h10;
   localparam logic [5:0] MTHI  = 6'h11;
   localparam logic [5:0] MFLO  = 6'h12;
   localparam logic [5:0] MTLO  = 6'h13;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MUL  = 2'd1,
      MD_DIV  = 2'd2,
      MD_FIX  = 2'd3
   } md_state_e;

   // Magnitude of a value; unsigned ops pass the raw value through.
   // 0x80000000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v,
                                             input logic              is_signed);
      return (is_signed && v[DATA_W-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/md_divider.sv
// md_divider: iterative restoring divider core on unsigned magnitudes.
//   CLK        clock
//   RST        synchronous active-high reset
//   start      load dividend/divisor at this edge and begin a new division
//   dividend   unsigned dividend
//   divisor    unsigned divisor (zero yields quotient all-ones, remainder = dividend)
//   quotient   quotient register, final from the cycle after done
//   remainder  remainder register, final from the cycle after done
//   done       high during the last iteration
module md_divider #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 6
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic              done
);

   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              run_q, run_d;
   logic [DATA_W:0]   shifted;
   logic [DATA_W:0]   diff;

   assign done      = run_q && (cnt_q == CNT_W'(DATA_W - 1));
   assign quotient  = quo_q;
   assign remainder = rem_q;

   always_comb begin
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      // Partial remainder with the next dividend bit shifted in.
      shifted = {rem_q, quo_q[DATA_W-1]};
      // diff[DATA_W] is the borrow: set means the trial subtraction failed.
      diff    = shifted - {1'b0, dvs_q};
      if (start) begin
         quo_d = dividend;
         rem_d = '0;
         dvs_d = divisor;
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         quo_d = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
         rem_d = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
         cnt_d = cnt_q + CNT_W'(1);
         if (done) begin
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Decodes the instruction word itself; issues MULT/MULTU/DIV/DIVU without stalling and
// stalls any later HI/LO instruction until the running operation has written HI/LO.
//   CLK       clock
//   RST       synchronous active-high reset (discards a running operation)
//   Ins       current instruction word (opcode Ins[31:26], funct Ins[5:0])
//   Rdata1    rs value: multiplicand / dividend / MTHI-MTLO source
//   Rdata2    rt value: multiplier / divisor
//   Stall     hold PC/Ins this cycle (combinational)
//   Busy      operation in progress (registered)
//   MdResult  HI for MFHI, LO for MFLO, else 0 (combinational)
//   HI, LO    architectural registers
// Build option: define MD_FAST_MUL_EN for a single-cycle multiply (2-cycle latency);
// otherwise the multiplier is a 32-cycle shift-add.
module md_unit import md_unit_pkg::*; #(
   parameter int unsigned DATA_W = md_unit_pkg::DATA_W,
   parameter int unsigned CNT_W  = 6
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [31:0]       Ins,
   input  logic [DATA_W-1:0] Rdata1,
   input  logic [DATA_W-1:0] Rdata2,
   output logic              Stall,
   output logic              Busy,
   output logic [DATA_W-1:0] MdResult,
   output logic [DATA_W-1:0] HI,
   output logic [DATA_W-1:0] LO
);

   md_state_e           state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   // Multiplier accumulator: upper half partial sum, lower half the remaining multiplier bits.
   logic [2*DATA_W-1:0] prod_q, prod_d;
   logic [DATA_W-1:0]   mcand_q, mcand_d;
   logic                q_neg_q, q_neg_d;
   logic                r_neg_q, r_neg_d;
   logic                div0_q, div0_d;
   logic                is_div_q, is_div_d;

   logic              rform;
   logic [5:0]        funct;
   logic              op_mul, op_div, op_signed;
   logic              op_mfhi, op_mflo, op_mthi, op_mtlo, op_hilo;
   logic [DATA_W-1:0] a_mag, b_mag;
   logic              div_start, div_done;
   logic [DATA_W-1:0] div_quo, div_rem;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0] quo_fix, rem_fix;
   logic              unused_ins;

   assign unused_ins = ^Ins[25:6];

   assign rform     = (Ins[31:26] == R_FORM);
   assign funct     = Ins[5:0];
   assign op_mul    = rform && (funct == MULT || funct == MULTU);
   assign op_div    = rform && (funct == DIV || funct == DIVU);
   assign op_signed = rform && (funct == MULT || funct == DIV);
   assign op_mfhi   = rform && (funct == MFHI);
   assign op_mflo   = rform && (funct == MFLO);
   assign op_mthi   = rform && (funct == MTHI);
   assign op_mtlo   = rform && (funct == MTLO);
   assign op_hilo   = op_mul || op_div || op_mfhi || op_mflo || op_mthi || op_mtlo;

   assign Stall    = busy_q && op_hilo;
   assign Busy     = busy_q;
   assign HI       = hi_q;
   assign LO       = lo_q;
   assign MdResult = op_mfhi ? hi_q : (op_mflo ? lo_q : '0);

   assign a_mag = mag(Rdata1, op_signed);
   assign b_mag = mag(Rdata2, op_signed);

   assign div_start = (state_q == MD_IDLE) && op_div;

   md_divider #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_divider (
      .CLK       (CLK),
      .RST       (RST),
      .start     (div_start),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (div_quo),
      .remainder (div_rem),
      .done      (div_done)
   );

   // Sign correction; a zero divisor forces the all-ones quotient while the remainder
   // negation restores the dividend exactly as it was given.
   assign prod_fix = q_neg_q ? -prod_q : prod_q;
   assign quo_fix  = div0_q ? '1 : (q_neg_q ? -div_quo : div_quo);
   assign rem_fix  = r_neg_q ? -div_rem : div_rem;

`ifndef MD_FAST_MUL_EN
   logic [DATA_W:0] mul_sum;
   assign mul_sum = {1'b0, prod_q[2*DATA_W-1:DATA_W]} +
                    (prod_q[0] ? {1'b0, mcand_q} : '0);
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      div0_d   = div0_q;
      is_div_d = is_div_q;

      unique case (state_q)
         MD_IDLE: begin
            if (op_mul || op_div) begin
               mcand_d  = a_mag;
               prod_d   = {{DATA_W{1'b0}}, b_mag};
               q_neg_d  = op_signed && (Rdata1[DATA_W-1] ^ Rdata2[DATA_W-1]);
               r_neg_d  = op_signed && Rdata1[DATA_W-1];
               div0_d   = (Rdata2 == '0);
               is_div_d = op_div;
               cnt_d    = '0;
               state_d  = op_div ? MD_DIV : MD_MUL;
            end else if (op_mthi) begin
               hi_d = Rdata1;
            end else if (op_mtlo) begin
               lo_d = Rdata1;
            end
         end
         MD_MUL: begin
`ifdef MD_FAST_MUL_EN
            prod_d  = {{DATA_W{1'b0}}, mcand_q} * {{DATA_W{1'b0}}, prod_q[DATA_W-1:0]};
            state_d = MD_FIX;
`else
            prod_d = {mul_sum, prod_q[DATA_W-1:1]};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               state_d = MD_FIX;
            end
`endif
         end
         MD_DIV: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (div_done) begin
               state_d = MD_FIX;
            end
         end
         MD_FIX: begin
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*DATA_W-1:DATA_W];
               lo_d = prod_fix[DATA_W-1:0];
            end
            state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase

      busy_d = (state_d != MD_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= MD_IDLE;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         prod_q   <= '0;
         mcand_q  <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         div0_q   <= 1'b0;
         is_div_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         div0_q   <= div0_d;
         is_div_q <= is_div_d;
      end
   end

endmodule
